// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: multi-cycle MULT/MULTU/DIV/DIVU
// with fixed, parameterised latency, plus single-cycle MTHI/MTLO writes.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDUOP,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        MFOP,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOUT
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    op_q, op_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          done_q, done_d;

   logic          signed_op, is_div, a_neg, b_neg;
   logic [63:0]   a_ext, b_ext, product;
   logic [31:0]   a_mag, b_mag, divisor, quot_mag, rem_mag, quot, rem;

   // Result datapath works on the latched operands only.
   always_comb begin
      signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
      is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
      a_ext     = {{32{signed_op & a_q[31]}}, a_q};
      b_ext     = {{32{signed_op & b_q[31]}}, b_q};
      product   = a_ext * b_ext;
      // Signed divide via magnitudes: 0x80000000 / -1 naturally yields 0x80000000.
      a_neg     = signed_op & a_q[31];
      b_neg     = signed_op & b_q[31];
      a_mag     = a_neg ? (32'd0 - a_q) : a_q;
      b_mag     = b_neg ? (32'd0 - b_q) : b_q;
      divisor   = (b_mag == 32'd0) ? 32'd1 : b_mag;
      quot_mag  = a_mag / divisor;
      rem_mag   = a_mag % divisor;
      quot      = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
      rem       = a_neg ? (32'd0 - rem_mag) : rem_mag;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (MDUOP)
                  OP_MULT, OP_MULTU: begin
                     op_d    = MDUOP;
                     a_d     = A;
                     b_d     = B;
                     cnt_d   = CW'(MULT_CYCLES - 1);
                     state_d = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     op_d    = MDUOP;
                     a_d     = A;
                     b_d     = B;
                     cnt_d   = CW'(DIV_CYCLES - 1);
                     state_d = RUN;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (!is_div) begin
                  hi_d = product[63:32];
                  lo_d = product[31:0];
               end else if (b_q != 32'd0) begin
                  lo_d = quot;
                  hi_d = rem;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign HI     = hi_q;
   assign LO     = lo_q;
   assign MDUOUT = MFOP ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases with literal expectations plus
// randomized traffic checked every cycle against a latency-scheduled reference model.
module tb_mdu;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  MDUOP = 3'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        MFOP = 1'b0;
   logic        busy, done;
   logic [31:0] HI, LO, MDUOUT;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .MDUOP(MDUOP), .A(A), .B(B),
      .MFOP(MFOP), .busy(busy), .done(done), .HI(HI), .LO(LO), .MDUOUT(MDUOUT)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the operation definitions.
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, output bit write);
      longint      sa, sb, q, r;
      logic [63:0] res;
      write = 1'b1;
      res   = 64'd0;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      case (op)
         3'd1: res = sa * sb;
         3'd2: res = {32'd0, a} * {32'd0, b};
         3'd3: begin
            if (b == 32'd0) write = 1'b0;
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd4: begin
            if (b == 32'd0) write = 1'b0;
            else res = {a % b, a / b};
         end
         default: write = 1'b0;
      endcase
      return res;
   endfunction

   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic [63:0] m_res = 64'd0;
   bit          m_write = 1'b0;
   bit          m_done = 1'b0;
   int          m_rem = 0;

   // Model: an accepted op completes 'latency' edges later; compare every cycle.
   always @(posedge clk) begin
      if (!reset) begin
         m_hi = 0; m_lo = 0; m_rem = 0; m_done = 0; m_write = 0;
      end else begin
         m_done = 0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               if (m_write) {m_hi, m_lo} = m_res;
               m_done = 1;
            end
         end else if (start) begin
            if (MDUOP >= 3'd1 && MDUOP <= 3'd4) begin
               m_res = ref_result(MDUOP, A, B, m_write);
               m_rem = (MDUOP <= 3'd2) ? MC : DC;
            end else if (MDUOP == 3'd5) m_hi = A;
            else if (MDUOP == 3'd6) m_lo = A;
         end
      end
      #1;
      if (reset) begin
         check("model_busy", busy, (m_rem > 0));
         check("model_done", done, m_done);
         check("model_hi", HI, m_hi);
         check("model_lo", LO, m_lo);
         check("model_mduout", MDUOUT, MFOP ? m_hi : m_lo);
      end
   end

   // Drive a command at the +2 phase; returns at the +2 phase after the accept edge.
   task automatic cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; MDUOP = op; A = a; B = b;
      @(posedge clk); #2;
      start = 1'b0; MDUOP = 3'($urandom); A = $urandom; B = $urandom;
   endtask

   task automatic wait_done(output int n);
      bit seen = 0;
      n = 0;
      repeat (40) if (!seen) begin
         @(posedge clk); #1;
         n++;
         seen = done;
      end
      check("done_seen", seen, 1);
      #1;
   endtask

   task automatic idle_cycles(input int k, output int done_cnt);
      done_cnt = 0;
      repeat (k) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
         #1;
      end
   endtask

   int n, dcnt;

   initial begin
      #1;
      check("rst_hi", HI, 0);
      check("rst_lo", LO, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk); #2;
      reset = 1'b1;

      // First edge after release must accept.
      cmd(3'd6, 32'h55, 32'd0);
      check("first_mtlo", LO, 32'h55);
      check("mtlo_busy", busy, 0);

      cmd(3'd1, 32'hFFFFFFFE, 32'd3);
      check("mult_busy_now", busy, 1);
      wait_done(n);
      check("mult_latency", n, MC);
      check("mult_hi", HI, 32'hFFFFFFFF);
      check("mult_lo", LO, 32'hFFFFFFFA);
      check("mult_busy_done", busy, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      #1;

      cmd(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(n);
      check("multu_hi", HI, 32'hFFFFFFFE);
      check("multu_lo", LO, 32'h00000001);

      cmd(3'd3, 32'hFFFFFFF9, 32'd2);
      wait_done(n);
      check("div_latency", n, DC);
      check("div_lo", LO, 32'hFFFFFFFD);
      check("div_hi", HI, 32'hFFFFFFFF);
      cmd(3'd4, 32'hFFFFFFF9, 32'd2);
      wait_done(n);
      check("divu_lo", LO, 32'h7FFFFFFC);
      check("divu_hi", HI, 32'h00000001);

      MFOP = 1'b1;
      cmd(3'd5, 32'h1234, 32'd0);
      check("mthi_mduout", MDUOUT, 32'h1234);
      MFOP = 1'b0;

      // Second start while busy is dropped.
      cmd(3'd2, 32'd7, 32'd9);
      cmd(3'd4, 32'd100, 32'd3);
      wait_done(n);
      check("ignored_latency", n, MC - 1);
      check("ignored_hi", HI, 32'd0);
      check("ignored_lo", LO, 32'd63);
      idle_cycles(DC + 2, dcnt);
      check("ignored_no_done", dcnt, 0);

      cmd(3'd6, 32'hAA, 32'd0);
      cmd(3'd3, 32'd1000, 32'd0);
      wait_done(n);
      check("div0_latency", n, DC);
      check("div0_lo", LO, 32'hAA);
      check("div0_hi", HI, 32'd0);
      cmd(3'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_done(n);
      check("divovf_lo", LO, 32'h80000000);
      check("divovf_hi", HI, 32'd0);

      // Reset mid-MULT clears asynchronously and leaves nothing pending.
      cmd(3'd1, 32'h10000, 32'h10000);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_hi", HI, 0);
      check("arst_lo", LO, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      idle_cycles(MC + 4, dcnt);
      check("arst_no_done", dcnt, 0);
      check("arst_hi_after", HI, 0);
      check("arst_lo_after", LO, 0);

      // Randomized traffic, checked by the model every cycle.
      repeat (1500) begin
         start = ($urandom_range(0, 2) != 0);
         MDUOP = 3'($urandom);
         A = $urandom;
         B = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 19) == 0) begin
            A = 32'h80000000;
            B = 32'hFFFFFFFF;
         end
         MFOP = 1'($urandom);
         @(posedge clk); #2;
      end
      start = 1'b0;
      repeat (DC + 3) @(posedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
